serial_adder: RTL and testbench

Bit-serial adder that sums two WIDTH-bit operands one bit per clock, LSB first, through a single `full_adder` instance with a registered carry. It is the sequential stage directly around the existing `full_adder`: it feeds operand bits and the stored carry into the `full_adder` inputs `a`, `b` and `c`, and consumes its `sum` and `carry` outputs. It trades latency for area wherever a parallel ripple adder is too large.

---
 rtl/serial_adder.sv | 114 +++++++++++
 tb/tb_serial_adder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder step per clock, LSB first, carry held in a flop.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh;
    logic             c_q;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_co;
    logic             load, last;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .c    (c_q),
        .sum  (fa_s),
        .carry(fa_co)
    );

    // start is only honoured outside RUN, which also covers back-to-back from DONE
    assign load = start && (state != RUN);
    assign last = (state == RUN) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            s_sh <= '0;
            c_q  <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf  <= 1'b0;
`endif
        end else if (load) begin
            a_sh <= a;
            b_sh <= b;
            s_sh <= '0;
            c_q  <= cin;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            s_sh <= {fa_s, s_sh[WIDTH-1:1]};
            c_q  <= fa_co;
            cnt  <= cnt + CW'(1);
            // Result registers only move on the MSB step so they hold between completions
            if (last) begin
                sum  <= {fa_s, s_sh[WIDTH-1:1]};
                cout <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                ovf  <= c_q ^ fa_co;
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed bench for serial_adder (WIDTH=8) against an arithmetic reference.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    bit both_hi = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy && done) both_hi = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Present operands and start for one edge; returns just after the accepting edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        start = 1'b1; a = ta; b = tb; cin = tc;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] ta,
                                input logic [W-1:0] tb, input logic tc, input int cyc);
        logic [W:0] ref_sum;
        ref_sum = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        check({tag, " latency"}, cyc, W);
        check({tag, " done"}, done, 1'b1);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " sum"}, sum, ref_sum[W-1:0]);
        check({tag, " cout"}, cout, ref_sum[W]);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, " ovf"}, ovf,
              (ta[W-1] == tb[W-1]) && (ref_sum[W-1] != ta[W-1]));
`endif
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta,
                          input logic [W-1:0] tb, input logic tc);
        int cyc;
        start_op(ta, tb, tc);
        wait_done(cyc);
        check_result(tag, ta, tb, tc, cyc);
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        int dn;
        logic [W-1:0] prev;
        logic [W-1:0] ta, tb;
        logic         tc;

        repeat (3) @(posedge clk);
        start = 1'b1;  // reset must win over start
        @(posedge clk); #1;
        start = 1'b0;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset sum", sum, '0);
        check("reset cout", cout, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("zero", 8'h00, 8'h00, 1'b0);
        run_op("ff+01", 8'hFF, 8'h01, 1'b0);
        run_op("7f+01", 8'h7F, 8'h01, 1'b0);
        run_op("80+80", 8'h80, 8'h80, 1'b0);

        // Back-to-back: start held while in DONE
        start_op(8'hA5, 8'h5A, 1'b1);
        wait_done(cyc);
        check_result("a5+5a+1", 8'hA5, 8'h5A, 1'b1, cyc);
        prev = sum;
        start_op(8'h12, 8'h34, 1'b0);
        check("b2b busy", busy, 1'b1);
        check("b2b sum hold", sum, prev);
        wait_done(cyc);
        check("b2b spacing", cyc + 1, W + 1);
        check_result("12+34", 8'h12, 8'h34, 1'b0, cyc);
        @(posedge clk); #1;

        // Start during RUN is ignored
        start_op(8'h01, 8'h02, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 3;
        while (!done && cyc < 40) begin @(posedge clk); #1; cyc++; end
        check_result("ignore start", 8'h01, 8'h02, 1'b0, cyc);
        @(posedge clk); #1;
        check("idle after done", busy | done, 1'b0);

        // Reset in the middle of RUN
        start_op(8'h55, 8'h66, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst busy", busy, 1'b0);
        check("midrst sum", sum, '0);
        check("midrst cout", cout, 1'b0);
        dn = 0;
        repeat (W + 3) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check("midrst no done", dn, 0);
        run_op("after rst", 8'h3C, 8'hC3, 1'b1);

        // Random operands, operand buses scrambled during RUN
        for (int i = 0; i < 40; i++) begin
            ta = W'($urandom); tb = W'($urandom); tc = 1'($urandom);
            if (i % 3 == 0) begin
                run_op("rand", ta, tb, tc);
            end else begin
                start_op(ta, tb, tc);
                wait_done(cyc);
                check_result("rand b2b", ta, tb, tc, cyc);
            end
        end
        @(posedge clk); #1;

        check("busy&done never", both_hi, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
